d_cache_2way: RTL and testbench
===============================

D_CACHE_2WAY -- requirements
Module: d_cache_2way

Interface
REQ-001 Parameter A_WIDTH, default 32: physical address width.
REQ-002 Parameter C_INDEX, default 7: set-index bits; 2^C_INDEX sets.
REQ-003 Parameter LINE_W, default 2: word-offset bits; 2^LINE_W 32-bit words per line; tag width T = A_WIDTH-C_INDEX-LINE_W-2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 memenM  in  1  CPU access strobe, held until cache_ready.
REQ-007 memwriteM  in  1  1 = store, 0 = load.
REQ-008 sel  in  4  store byte enables, bit3 = [31:24].
REQ-009 data_sram_size  in  2  access size (0 byte, 1 half, 2 word).
REQ-010 data_paddr  in  A_WIDTH  physical address; split into tag | index | offset | 2'b00.
REQ-011 writedata2M  in  32  store data.
REQ-012 uncached  in  1  1 = bypass the cache for this access.
REQ-013 readdataM  out  32  load data, valid while cache_ready=1.
REQ-014 cache_ready  out  1  access complete this cycle.
REQ-015 data_req  out  1  memory request, held until data_addr_ok.
REQ-016 data_wr  out  1  1 = memory write.
REQ-017 data_wen / data_size / data_addr / data_wdata  out  4/2/32/32  memory byte enables, size, address, write data.
REQ-018 data_rdata  in  32; data_addr_ok  in  1; data_data_ok  in  1  memory read data and handshake.

Function
REQ-019 Organisation SHALL be 2-way set-associative, write-back, write-allocate, one LRU bit per set; per way per set: valid, dirty, tag, 2^LINE_W data words.
REQ-020 States SHALL be IDLE, WB, FILL, UNC; only IDLE accepts a new access.
REQ-021 Hit (IDLE, memenM, !uncached, valid & tag match in either way) SHALL assert cache_ready combinationally in the same cycle, readdataM = addressed word of the hit way.
REQ-022 Store hit SHALL merge writedata2M bytes per sel into the hit word on that edge and set dirty; sel=0000 SHALL write nothing but still set dirty.
REQ-023 Every hit SHALL set LRU to point at the other way.
REQ-024 Miss victim: invalid way 0 first, else invalid way 1, else LRU way; victim dirty -> WB, else -> FILL.
REQ-025 WB SHALL write the victim line word 0..N-1 to {victim_tag, index, word, 2'b00}, data_wr=1, data_wen=1111, data_size=2; after the last data_data_ok -> FILL.
REQ-026 FILL SHALL read words 0..N-1 from {tag, index, word, 2'b00}, data_wr=0, storing each word on data_data_ok; after the last word: victim valid=1, dirty=0, tag written -> IDLE; the retried access hits the following cycle.
REQ-027 Per word: data_req high with stable address until the cycle data_addr_ok=1, then low until data_data_ok=1; one outstanding transaction; addr_ok and data_ok in the same cycle SHALL complete the word.
REQ-028 A word counter of LINE_W bits SHALL wrap to 0 on leaving WB or FILL.
REQ-029 UNC: one transaction to data_paddr with data_wr=memwriteM, data_wen=sel (0000 on loads), data_size=data_sram_size, data_wdata=writedata2M; on data_data_ok cache_ready=1 for one cycle, readdataM=data_rdata, -> IDLE; cache state untouched, even if the line is cached.
REQ-030 cache_ready SHALL be 0 in WB and FILL; readdataM SHALL be 0 when cache_ready=0.
REQ-031 Inputs SHALL be held constant by the CPU while memenM=1 and cache_ready=0; memenM dropping mid-miss SHALL not abort the line operation.

Reset
REQ-032 rst SHALL clear all valid, dirty and LRU bits, state=IDLE, counter=0, data_req=0, data_wr=0, cache_ready=0 immediately; tags and data are not reset.
REQ-033 rst during WB/FILL SHALL abandon the transaction; the line is left invalid.

Verification
REQ-034 Cold load 0x0000_1000, memory 0x1000..0x100C = A,B,C,D -> 4 FILL reads at 0x1000,0x1004,0x1008,0x100C, then cache_ready with readdataM=A; load 0x1008 -> same-cycle hit, readdataM=C.
REQ-035 Store sel=0011 data 0x1234_5678 to cached 0x1004 (B=0xAAAA_AAAA) -> word 0xAAAA_5678, dirty=1, no memory traffic.
REQ-036 Fill 0x1000 (way0) and 0x2000 (way1) in set 0; touch 0x1000; load 0x3000 -> way1 evicted; store to 0x3000 then load 0x4000 -> LRU way is now way0 (clean 0x1000) replaced without WB.
REQ-037 Dirty victim: after REQ-035, fill two other tags in that set -> 4 WB writes to 0x1000..0x100C, second word 0xAAAA_5678, before the FILL reads.
REQ-038 Uncached store sel=0100 to 0x1FC0_0000 -> single transaction data_wen=0100, data_size=0; cache contents unchanged.
REQ-039 data_addr_ok held low 5 cycles then addr_ok and data_ok in the same cycle -> data_req stable for 6 cycles, word accepted once; assert rst mid-FILL -> data_req=0 at once, next access misses.

Source files
------------

// File: rtl/d_cache_2way.sv
// rtl/d_cache_2way.sv - 2-way set-associative write-back, write-allocate data cache
// Per-set LRU bit names the way to evict next; line moves use a one-outstanding req/addr_ok/data_ok handshake.
module d_cache_2way #(
    parameter int A_WIDTH = 32,
    parameter int C_INDEX = 7,
    parameter int LINE_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memenM,
    input  logic               memwriteM,
    input  logic [3:0]         sel,
    input  logic [1:0]         data_sram_size,
    input  logic [A_WIDTH-1:0] data_paddr,
    input  logic [31:0]        writedata2M,
    input  logic               uncached,
    output logic [31:0]        readdataM,
    output logic               cache_ready,
    output logic               data_req,
    output logic               data_wr,
    output logic [3:0]         data_wen,
    output logic [1:0]         data_size,
    output logic [31:0]        data_addr,
    output logic [31:0]        data_wdata,
    input  logic [31:0]        data_rdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok
);
    localparam int T     = A_WIDTH - C_INDEX - LINE_W - 2;
    localparam int SETS  = 1 << C_INDEX;
    localparam int WORDS = 1 << LINE_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_UNC  = 2'd3;

    logic [31:0]        r_data0 [SETS*WORDS];
    logic [31:0]        r_data1 [SETS*WORDS];
    logic [T-1:0]       r_tag0  [SETS];
    logic [T-1:0]       r_tag1  [SETS];
    logic [SETS-1:0]    r_valid0, r_valid1, r_dirty0, r_dirty1, r_lru;
    logic [1:0]         r_state;
    logic [LINE_W-1:0]  r_cnt;
    logic               r_wait;
    logic               r_way;
    logic [C_INDEX-1:0] r_idx;
    logic [T-1:0]       r_ftag;

    logic [T-1:0]              w_tag;
    logic [C_INDEX-1:0]        w_index;
    logic [LINE_W-1:0]         w_off;
    logic [C_INDEX+LINE_W-1:0] w_widx, w_lidx;
    logic                      w_hit0, w_hit1, w_hit_ok, w_miss, w_victim, w_vdirty;
    logic                      w_done, w_last, w_fill_wr;
    logic [31:0]               w_rd0, w_rd1, w_hit_word, w_merged, w_vword;
    logic [T-1:0]              w_vtag;
    logic [A_WIDTH-1:0]        w_addr;

    assign w_tag      = data_paddr[A_WIDTH-1 -: T];
    assign w_index    = data_paddr[LINE_W+2 +: C_INDEX];
    assign w_off      = data_paddr[2 +: LINE_W];
    assign w_widx     = {w_index, w_off};
    assign w_lidx     = {r_idx, r_cnt};
    assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
    assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
    assign w_rd0      = r_data0[w_widx];
    assign w_rd1      = r_data1[w_widx];
    assign w_hit_word = w_hit0 ? w_rd0 : w_rd1;
    assign w_hit_ok   = (r_state == S_IDLE) && memenM && !uncached && (w_hit0 || w_hit1);
    assign w_miss     = (r_state == S_IDLE) && memenM && !uncached && !(w_hit0 || w_hit1);
    assign w_victim   = !r_valid0[w_index] ? 1'b0 : (!r_valid1[w_index] ? 1'b1 : r_lru[w_index]);
    assign w_vdirty   = w_victim ? (r_valid1[w_index] && r_dirty1[w_index])
                                 : (r_valid0[w_index] && r_dirty0[w_index]);
    assign w_vtag     = r_way ? r_tag1[r_idx] : r_tag0[r_idx];
    assign w_vword    = r_way ? r_data1[w_lidx] : r_data0[w_lidx];

    // A word completes when data_ok arrives, either with addr_ok or after it.
    assign data_req  = (r_state != S_IDLE) && !r_wait;
    assign w_done    = (data_req && data_addr_ok && data_data_ok) || (r_wait && data_data_ok);
    assign w_last    = (r_cnt == {LINE_W{1'b1}});
    assign w_fill_wr = (r_state == S_FILL) && w_done;

    always_comb begin
        w_merged = w_hit_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) w_merged[8*b +: 8] = writedata2M[8*b +: 8];
        end
    end

    assign cache_ready = w_hit_ok || ((r_state == S_UNC) && w_done);
    assign readdataM   = w_hit_ok ? w_hit_word :
                         (((r_state == S_UNC) && w_done) ? data_rdata : 32'h0);

    always_comb begin
        w_addr     = '0;
        data_wr    = 1'b0;
        data_wen   = 4'b0000;
        data_size  = 2'd2;
        data_wdata = 32'h0;
        case (r_state)
            S_WB: begin
                w_addr     = {w_vtag, r_idx, r_cnt, 2'b00};
                data_wr    = 1'b1;
                data_wen   = 4'b1111;
                data_wdata = w_vword;
            end
            S_FILL: w_addr = {r_ftag, r_idx, r_cnt, 2'b00};
            S_UNC: begin
                w_addr     = data_paddr;
                data_wr    = memwriteM;
                data_wen   = memwriteM ? sel : 4'b0000;
                data_size  = data_sram_size;
                data_wdata = writedata2M;
            end
            default: ;
        endcase
    end
    assign data_addr = 32'(w_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wait   <= 1'b0;
            r_way    <= 1'b0;
            r_idx    <= '0;
            r_ftag   <= '0;
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_dirty0 <= '0;
            r_dirty1 <= '0;
            r_lru    <= '0;
        end else begin
            if (w_done)
                r_wait <= 1'b0;
            else if (data_req && data_addr_ok)
                r_wait <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_hit_ok) begin
                        r_lru[w_index] <= w_hit0;
                        if (memwriteM) begin
                            if (w_hit0) r_dirty0[w_index] <= 1'b1;
                            else        r_dirty1[w_index] <= 1'b1;
                        end
                    end else if (w_miss) begin
                        r_idx   <= w_index;
                        r_ftag  <= w_tag;
                        r_way   <= w_victim;
                        r_state <= w_vdirty ? S_WB : S_FILL;
                    end else if (memenM && uncached) begin
                        r_state <= S_UNC;
                    end
                end
                S_WB: if (w_done) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FILL;
                end
                S_FILL: if (w_done) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (r_way) begin
                            r_valid1[r_idx] <= 1'b1;
                            r_dirty1[r_idx] <= 1'b0;
                        end else begin
                            r_valid0[r_idx] <= 1'b1;
                            r_dirty0[r_idx] <= 1'b0;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: if (w_done) r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays are plain storage; validity alone guards them after reset.
    always_ff @(posedge clk) begin
        if (w_hit_ok && memwriteM && w_hit0)
            r_data0[w_widx] <= w_merged;
        else if (w_fill_wr && !r_way)
            r_data0[w_lidx] <= data_rdata;
        if (w_hit_ok && memwriteM && !w_hit0)
            r_data1[w_widx] <= w_merged;
        else if (w_fill_wr && r_way)
            r_data1[w_lidx] <= data_rdata;
        if (w_fill_wr && w_last) begin
            if (r_way) r_tag1[r_idx] <= r_ftag;
            else       r_tag0[r_idx] <= r_ftag;
        end
    end
endmodule

// File: tb/tb_d_cache_2way.sv
// tb/tb_d_cache_2way.sv - directed bench for d_cache_2way with a negedge-driven memory responder
module tb_d_cache_2way;
    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, uncached;
    logic [3:0]  sel;
    logic [1:0]  data_sram_size;
    logic [31:0] data_paddr, writedata2M, readdataM;
    logic        cache_ready, data_req, data_wr;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    int checks = 0;
    int errors = 0;

    d_cache_2way dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .sel(sel),
        .data_sram_size(data_sram_size), .data_paddr(data_paddr), .writedata2M(writedata2M),
        .uncached(uncached), .readdataM(readdataM), .cache_ready(cache_ready),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] WA = 32'h1111_0000;
    localparam logic [31:0] WB = 32'hAAAA_AAAA;
    localparam logic [31:0] WC = 32'hCCCC_0008;
    localparam logic [31:0] WD = 32'hDDDD_000C;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic [31:0] log_wdata [$];
    logic        log_wr [$];
    logic [3:0]  log_wen [$];
    logic [1:0]  log_size [$];
    int          log_lat [$];
    int          addr_delay = 0;
    int          wait_cnt = 0;
    int          addr_unstable = 0;
    int          rdz_viol = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] resp_w;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory decides at negedge; the DUT consumes the response on the next posedge.
    always @(negedge clk) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (data_req) begin
            if (wait_cnt > 0 && data_addr !== prev_addr) addr_unstable++;
            prev_addr = data_addr;
            if (wait_cnt >= addr_delay) begin
                data_addr_ok = 1'b1;
                data_data_ok = 1'b1;
                data_rdata   = mem_rd(data_addr);
                if (data_wr) begin
                    resp_w = mem_rd(data_addr);
                    for (int b = 0; b < 4; b++)
                        if (data_wen[b]) resp_w[8*b +: 8] = data_wdata[8*b +: 8];
                    mem[data_addr] = resp_w;
                end
                log_addr.push_back(data_addr);
                log_wdata.push_back(data_wdata);
                log_wr.push_back(data_wr);
                log_wen.push_back(data_wen);
                log_size.push_back(data_size);
                log_lat.push_back(wait_cnt + 1);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_wdata.delete(); log_wr.delete();
        log_wen.delete(); log_size.delete(); log_lat.delete();
    endtask

    task automatic access(input logic we, input logic [3:0] s, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic unc,
                          output logic [31:0] rd, output int cyc);
        @(negedge clk); #1;
        memenM = 1'b1; memwriteM = we; sel = s; data_sram_size = sz;
        data_paddr = a; writedata2M = wd; uncached = unc;
        cyc = -1;
        rd  = '0;
        for (int i = 0; i < 300; i++) begin
            #2;
            if (cache_ready) begin
                rd  = readdataM;
                cyc = i;
                break;
            end
            if (readdataM !== 32'h0) rdz_viol++;
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        memenM = 1'b0; memwriteM = 1'b0; uncached = 1'b0; sel = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memenM = 1'b0; memwriteM = 1'b0; uncached = 1'b0; sel = 4'b0000;
        data_sram_size = 2'd2; data_paddr = '0; writedata2M = '0;
        data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (cache_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cache_ready); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", data_req); end
        checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", data_wr); end
        checks++; if (readdataM !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", readdataM); end
        rst = 1'b0;
    endtask

    task automatic test_cold_fill();
        logic [31:0] rd;
        int cyc;
        mem[32'h1000] = WA; mem[32'h1004] = WB; mem[32'h1008] = WC; mem[32'h100C] = WD;
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h1000, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc <= 0) begin errors++; $display("FAIL cold_miss_latency got %0d want >0", cyc); end
        checks++; if (rd !== WA) begin errors++; $display("FAIL cold_data got %h want %h", rd, WA); end
        checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL cold_count got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 32'h1000 + 32'(4*i) || log_wr[i] !== 1'b0)
                begin errors++; $display("FAIL cold_read%0d got %h/%b want %h/0", i, log_addr[i], log_wr[i], 32'h1000 + 32'(4*i)); end
        end
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h1008, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL hit_latency got %0d want 0", cyc); end
        checks++; if (rd !== WC) begin errors++; $display("FAIL hit_data got %h want %h", rd, WC); end
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL hit_traffic got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        int cyc;
        clear_log();
        access(1'b1, 4'b0011, 2'd2, 32'h1004, 32'h1234_5678, 1'b0, rd, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL store_hit_latency got %0d want 0", cyc); end
        access(1'b1, 4'b0000, 2'd2, 32'h100C, 32'hFFFF_FFFF, 1'b0, rd, cyc);
        access(1'b0, 4'b0000, 2'd2, 32'h1004, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'hAAAA_5678) begin errors++; $display("FAIL store_merge got %h want aaaa5678", rd); end
        access(1'b0, 4'b0000, 2'd2, 32'h100C, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== WD) begin errors++; $display("FAIL store_sel0 got %h want %h", rd, WD); end
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL store_traffic got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_dirty_victim();
        logic [31:0] rd;
        int cyc;
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h2000, 32'h0, 1'b0, rd, cyc);
        checks++; if (log_addr.size() != 4 || log_wr[0] !== 1'b0) begin errors++; $display("FAIL second_way_fill got %0d entries want 4 reads", log_addr.size()); end
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h3000, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'h5A5A_3000) begin errors++; $display("FAIL victim_fill_data got %h want 5a5a3000", rd); end
        checks++; if (log_addr.size() != 8) begin errors++; $display("FAIL wb_count got %0d want 8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            checks++;
            if (i < 4) begin
                if (log_wr[i] !== 1'b1 || log_addr[i] !== 32'h1000 + 32'(4*i) || log_wen[i] !== 4'hF || log_size[i] !== 2'd2)
                    begin errors++; $display("FAIL wb_word%0d got %h wr=%b wen=%b want %h wr=1 wen=1111", i, log_addr[i], log_wr[i], log_wen[i], 32'h1000 + 32'(4*i)); end
            end else begin
                if (log_wr[i] !== 1'b0 || log_addr[i] !== 32'h3000 + 32'(4*(i-4)))
                    begin errors++; $display("FAIL wb_fill%0d got %h wr=%b want %h wr=0", i, log_addr[i], log_wr[i], 32'h3000 + 32'(4*(i-4))); end
            end
        end
        if (log_wdata.size() >= 4) begin
            checks++; if (log_wdata[0] !== WA) begin errors++; $display("FAIL wb_data0 got %h want %h", log_wdata[0], WA); end
            checks++; if (log_wdata[1] !== 32'hAAAA_5678) begin errors++; $display("FAIL wb_data1 got %h want aaaa5678", log_wdata[1]); end
            checks++; if (log_wdata[3] !== WD) begin errors++; $display("FAIL wb_data3 got %h want %h", log_wdata[3], WD); end
        end
    endtask

    task automatic test_lru();
        logic [31:0] rd;
        int cyc;
        access(1'b0, 4'b0000, 2'd2, 32'h1010, 32'h0, 1'b0, rd, cyc);
        access(1'b0, 4'b0000, 2'd2, 32'h2010, 32'h0, 1'b0, rd, cyc);
        access(1'b0, 4'b0000, 2'd2, 32'h1010, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL lru_touch_hit got %0d want 0", cyc); end
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h3010, 32'h0, 1'b0, rd, cyc);
        checks++; if (log_addr.size() != 4 || log_wr[0] !== 1'b0) begin errors++; $display("FAIL lru_clean_evict got %0d entries want 4 reads", log_addr.size()); end
        access(1'b0, 4'b0000, 2'd2, 32'h1010, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc !== 0) begin errors++; $display("FAIL lru_kept_way0 got %0d want 0", cyc); end
        access(1'b1, 4'b1111, 2'd2, 32'h3010, 32'hCAFE_F00D, 1'b0, rd, cyc);
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h4010, 32'h0, 1'b0, rd, cyc);
        checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL lru_no_wb got %0d want 4", log_addr.size()); end
        for (int i = 0; i < log_wr.size(); i++) begin
            checks++; if (log_wr[i] !== 1'b0) begin errors++; $display("FAIL lru_no_wb_wr%0d got %b want 0", i, log_wr[i]); end
        end
        access(1'b0, 4'b0000, 2'd2, 32'h3010, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc !== 0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL lru_dirty_kept got %h/%0d want cafef00d/0", rd, cyc); end
    endtask

    task automatic test_uncached();
        logic [31:0] rd;
        int cyc;
        clear_log();
        access(1'b1, 4'b0100, 2'd0, 32'h1FC0_0000, 32'h00AB_0000, 1'b1, rd, cyc);
        checks++; if (cyc < 1) begin errors++; $display("FAIL unc_ready got %0d want >=1", cyc); end
        checks++; if (log_addr.size() != 1) begin errors++; $display("FAIL unc_count got %0d want 1", log_addr.size()); end
        if (log_addr.size() >= 1) begin
            checks++;
            if (log_addr[0] !== 32'h1FC0_0000 || log_wr[0] !== 1'b1 || log_wen[0] !== 4'b0100 || log_size[0] !== 2'd0 || log_wdata[0] !== 32'h00AB_0000)
                begin errors++; $display("FAIL unc_store got %h wr=%b wen=%b size=%0d wd=%h want 1fc00000 1 0100 0 00ab0000", log_addr[0], log_wr[0], log_wen[0], log_size[0], log_wdata[0]); end
        end
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h3010, 32'h0, 1'b1, rd, cyc);
        checks++; if (rd !== 32'h5A5A_3010) begin errors++; $display("FAIL unc_load got %h want 5a5a3010", rd); end
        checks++; if (log_addr.size() != 1 || log_wen[0] !== 4'b0000) begin errors++; $display("FAIL unc_load_txn got %0d entries want 1 with wen 0000", log_addr.size()); end
        access(1'b0, 4'b0000, 2'd2, 32'h3010, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc !== 0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL unc_cache_untouched got %h/%0d want cafef00d/0", rd, cyc); end
    endtask

    task automatic test_handshake();
        logic [31:0] rd;
        int cyc;
        addr_delay = 5;
        addr_unstable = 0;
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h5020, 32'h0, 1'b0, rd, cyc);
        checks++; if (rd !== 32'h5A5A_5020) begin errors++; $display("FAIL slow_data got %h want 5a5a5020", rd); end
        checks++; if (log_addr.size() != 4) begin errors++; $display("FAIL slow_count got %0d want 4", log_addr.size()); end
        if (log_lat.size() >= 4) begin
            checks++; if (log_lat[0] != 6) begin errors++; $display("FAIL slow_req_cycles0 got %0d want 6", log_lat[0]); end
            checks++; if (log_lat[3] != 6) begin errors++; $display("FAIL slow_req_cycles3 got %0d want 6", log_lat[3]); end
        end
        checks++; if (addr_unstable != 0) begin errors++; $display("FAIL slow_addr_stable got %0d want 0", addr_unstable); end
        addr_delay = 0;
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int cyc;
        addr_delay = 3;
        @(negedge clk); #1;
        memenM = 1'b1; memwriteM = 1'b0; sel = 4'b0000; data_sram_size = 2'd2;
        data_paddr = 32'h6030; uncached = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL midfill_req got %b want 1", data_req); end
        rst = 1'b1;
        #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL midfill_rst_req got %b want 0", data_req); end
        checks++; if (cache_ready !== 1'b0) begin errors++; $display("FAIL midfill_rst_ready got %b want 0", cache_ready); end
        @(negedge clk); #1;
        rst = 1'b0; memenM = 1'b0; addr_delay = 0;
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h6030, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc <= 0 || log_addr.size() != 4) begin errors++; $display("FAIL post_rst_miss got %0d/%0d want >0/4", cyc, log_addr.size()); end
        checks++; if (rd !== 32'h5A5A_6030) begin errors++; $display("FAIL post_rst_data got %h want 5a5a6030", rd); end
        clear_log();
        access(1'b0, 4'b0000, 2'd2, 32'h3010, 32'h0, 1'b0, rd, cyc);
        checks++; if (cyc <= 0) begin errors++; $display("FAIL post_rst_invalid got %0d want >0", cyc); end
    endtask

    task automatic test_idle_readdata_zero();
        checks++; if (rdz_viol != 0) begin errors++; $display("FAIL rdata_zero_when_not_ready got %0d want 0", rdz_viol); end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_store_hit();
        test_dirty_victim();
        test_lru();
        test_uncached();
        test_handshake();
        test_reset_mid_fill();
        test_idle_readdata_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
